// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM states,
// PC mux select codes and mult/div occupancy defaults.
package pipe_ctrl_pkg;

  localparam int MD_CYCLES_DEF = 32;
  localparam int MD_CNT_W      = 6;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_EXC = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-request and stage-control bundle between the datapath (master) and
// the pipeline controller (slave).
interface pipeline_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_rt;
  logic       ex_mem_read;
  logic       id_branch_taken;
  logic       id_jump;
  logic       md_start;
  logic       id_md_use;
  logic       exc_req;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_rs, id_rt, ex_rt, ex_mem_read, id_branch_taken, id_jump,
           md_start, id_md_use, exc_req,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel,
           md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_mem_read, id_branch_taken, id_jump,
           md_start, id_md_use, exc_req,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel,
           md_busy, md_done
  );
endinterface

// File: rtl/pipeline_ctrl_md_counter.sv
// Mult/div occupancy down-counter: load, decrement, synchronous clear and a
// zero flag used by the controller FSM to end the wait.
module md_counter
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                dec,
  input  logic                clear,
  input  logic [MD_CNT_W-1:0] load_val,
  output logic                zero
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  // NOTE: every combinational output gets its default before any branch so no latch is inferred.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (clear) begin
      md_cnt_d = '0;
    end else if (load) begin
      md_cnt_d = load_val;
    end else if (dec && (md_cnt_q != '0)) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign zero = (md_cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: load-use and mult/div stalls, branch/jump redirect,
// exception flush and the mult/div occupancy FSM.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

  state_e  state_q, state_d;
  logic    md_busy_q, md_busy_d;
  logic    md_done_q, md_done_d;
  logic    cnt_load, cnt_dec, cnt_clear, cnt_zero;
  logic    load_use, md_hazard, hazard;
  pc_sel_e pc_sel;

  assign load_use  = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                     ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  assign md_hazard = (state_q == MD_WAIT) && bus.id_md_use;
  assign hazard    = load_use || md_hazard;

  // Priority: reset, then exception, then stall, then redirect.
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    pc_sel          = PC_SEL_SEQ;
    if (reset) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else if (bus.exc_req) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
      pc_sel          = PC_SEL_EXC;
    end else if (hazard) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end else if (bus.id_branch_taken || bus.id_jump) begin
      bus.ifid_flush = 1'b1;
      pc_sel         = PC_SEL_BR;
    end
  end

  assign bus.pc_sel = pc_sel;

  always_comb begin
    state_d   = state_q;
    md_busy_d = md_busy_q;
    md_done_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.md_start && !bus.exc_req) begin
          state_d   = MD_WAIT;
          md_busy_d = 1'b1;
          cnt_load  = 1'b1;
        end
      end
      MD_WAIT: begin
        if (bus.exc_req) begin
          state_d   = RUN;
          md_busy_d = 1'b0;
          cnt_clear = 1'b1;
        end else if (cnt_zero) begin
          state_d   = RUN;
          md_busy_d = 1'b0;
          md_done_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
    end
  end

  md_counter u_md_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .load_val (MD_LOAD),
    .zero     (cnt_zero)
  );

  assign bus.md_busy = md_busy_q;
  assign bus.md_done = md_done_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed stimulus pushes the expected
// output vector each cycle; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MDC = 4;

  // Vector layout: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel[1:0], md_busy, md_done}
  localparam logic [8:0] NORM  = 9'b1_1_0_0_0_00_0_0;
  localparam logic [8:0] STALL = 9'b0_0_0_1_0_00_0_0;
  localparam logic [8:0] REDIR = 9'b1_1_1_0_0_01_0_0;
  localparam logic [8:0] EXC   = 9'b1_1_1_1_1_10_0_0;
  localparam logic [8:0] RST   = 9'b0_0_1_1_1_00_0_0;
  localparam logic [8:0] BUSY  = 9'b0_0_0_0_0_00_1_0;
  localparam logic [8:0] DONE  = 9'b0_0_0_0_0_00_0_1;

  typedef struct {
    string      name;
    logic [8:0] v;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name,
            {23'd0, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
             bus.exmem_flush, bus.pc_sel, bus.md_busy, bus.md_done},
            {23'd0, e.v});
    end
  end

  task automatic idle_in();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.ex_rt           = 5'd0;
    bus.ex_mem_read     = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.id_jump         = 1'b0;
    bus.md_start        = 1'b0;
    bus.id_md_use       = 1'b0;
    bus.exc_req         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic expect_v(input string name, input logic [8:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = r;
    bus.id_rs       = r;
  endtask

  initial begin
    idle_in();

    // Reset held: fixed outputs regardless of inputs
    step(); reset = 1'b1; load_use_rs(5'd3); bus.id_jump = 1'b1; bus.exc_req = 1'b1;
    expect_v("reset_hold", RST);
    step(); reset = 1'b0;                          expect_v("idle_after_reset", NORM);

    // Load-use hazard
    step(); load_use_rs(5'd5);                     expect_v("load_use_rs", STALL);
    step();                                        expect_v("load_use_clear", NORM);
    step(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7;
    expect_v("load_use_rt", STALL);
    step(); load_use_rs(5'd0);                     expect_v("load_use_r0", NORM);
    step(); bus.ex_rt = 5'd9; bus.id_rs = 5'd9;    expect_v("no_load_match", NORM);
    step(); load_use_rs(5'd4); bus.id_rs = 5'd6;   expect_v("load_no_match", NORM);

    // Branch under stall, then redirect once the hazard clears
    step(); load_use_rs(5'd5); bus.id_branch_taken = 1'b1; expect_v("branch_stalled", STALL);
    step(); bus.id_branch_taken = 1'b1;            expect_v("branch_resolved", REDIR);
    step(); bus.id_jump = 1'b1;                    expect_v("jump", REDIR);

    // Exception beats load-use and jump together
    step(); load_use_rs(5'd5); bus.id_jump = 1'b1; bus.exc_req = 1'b1;
    expect_v("exc_simul", EXC);

    // Mult/div: 4 busy cycles, md_start ignored, stall through the cnt==0 cycle
    step(); bus.md_start = 1'b1;                   expect_v("md_issue", NORM);
    step(); bus.id_md_use = 1'b1;                  expect_v("md_wait1", STALL | BUSY);
    step(); bus.id_md_use = 1'b1; bus.md_start = 1'b1; expect_v("md_wait2", STALL | BUSY);
    step(); bus.id_md_use = 1'b1; bus.md_start = 1'b1; expect_v("md_wait3", STALL | BUSY);
    step(); bus.id_md_use = 1'b1;                  expect_v("md_wait_zero", STALL | BUSY);
    step(); bus.id_md_use = 1'b1;                  expect_v("md_done", NORM | DONE);
    step(); bus.id_md_use = 1'b1;                  expect_v("md_after_done", NORM);

    // Exception aborts mult/div two cycles in
    step(); bus.md_start = 1'b1;                   expect_v("abort_issue", NORM);
    step();                                        expect_v("abort_wait", NORM | BUSY);
    step(); bus.exc_req = 1'b1;                    expect_v("abort_exc", EXC | BUSY);
    step(); bus.id_md_use = 1'b1;                  expect_v("abort_idle1", NORM);
    step(); bus.id_md_use = 1'b1;                  expect_v("abort_idle2", NORM);
    step();                                        expect_v("abort_idle3", NORM);

    // md_start with exc_req in RUN does not start
    step(); bus.md_start = 1'b1; bus.exc_req = 1'b1; expect_v("start_exc", EXC);
    step(); bus.id_md_use = 1'b1;                  expect_v("start_exc_after", NORM);

    // Reset mid-operation
    step(); bus.md_start = 1'b1;                   expect_v("rst_issue", NORM);
    step(); reset = 1'b1; bus.id_md_use = 1'b1;    expect_v("rst_mid1", RST | BUSY);
    step(); reset = 1'b1; bus.md_start = 1'b1;     expect_v("rst_mid2", RST);
    step(); reset = 1'b0; bus.id_md_use = 1'b1;    expect_v("rst_release", NORM);
    step(); bus.id_md_use = 1'b1;                  expect_v("rst_after1", NORM);
    step();                                        expect_v("rst_after2", NORM);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32: EX-stage mult/div occupancy in cycles, legal range 2..64.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 each: source registers of the ID instruction.
REQ-005 SHALL have port ex_rt, input, 5: destination register of the EX load.
REQ-006 SHALL have port ex_mem_read, input, 1: the EX instruction is a load.
REQ-007 SHALL have ports id_branch_taken and id_jump, input, 1 each: control transfer resolved in ID.
REQ-008 SHALL have port md_start, input, 1: a mult/div is issuing in EX this cycle.
REQ-009 SHALL have port id_md_use, input, 1: the ID instruction reads HI/LO or is a mult/div.
REQ-010 SHALL have port exc_req, input, 1: exception raised in MEM.
REQ-011 SHALL have ports pc_en, ifid_en, ifid_flush, idex_flush and exmem_flush, output, 1 each: stage enables and flushes.
REQ-012 SHALL have port pc_sel, output, 2: 00 = PC+4, 01 = branch/jump target, 10 = exception vector.
REQ-013 SHALL have ports md_busy and md_done, output, 1 each: mult/div busy level and a one-cycle completion pulse.

Function
REQ-014 SHALL implement an FSM with states RUN and MD_WAIT and a 6-bit down-counter md_cnt.
REQ-015 SHALL drive stage-control outputs combinationally from state and inputs in the same cycle; md_busy and md_done SHALL be registered.
REQ-016 SHALL define load-use hazard as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
REQ-017 SHALL define md hazard as state==MD_WAIT && id_md_use.
REQ-018 SHALL, on either hazard, drive pc_en=0, ifid_en=0 and idex_flush=1 (bubble); otherwise pc_en=ifid_en=1 and idex_flush=0.
REQ-019 SHALL, with no hazard and (id_branch_taken || id_jump), drive pc_sel=01 and ifid_flush=1.
REQ-020 SHALL, when a hazard coincides with a branch or jump, suppress the redirect (pc_sel=00, ifid_flush=0) so the branch re-resolves after the stall.
REQ-021 SHALL, on exc_req, override all other sources: pc_sel=10, pc_en=1, ifid_en=1, and ifid_flush=idex_flush=exmem_flush=1.
REQ-022 SHALL, in RUN with md_start && !exc_req, load md_cnt=MD_CYCLES-1, enter MD_WAIT and set md_busy=1 on the next edge.
REQ-023 SHALL, in MD_WAIT, decrement md_cnt each cycle; on the edge where md_cnt==0, return to RUN, clear md_busy and assert md_done for exactly one cycle.
REQ-024 SHALL ignore md_start while in MD_WAIT.
REQ-025 SHALL, on exc_req in MD_WAIT, abort the operation: next state RUN, md_cnt=0, md_busy=0, no md_done pulse.
REQ-026 SHALL, on md_start && exc_req in RUN, stay in RUN.
REQ-027 SHALL, when the md_cnt==0 edge coincides with id_md_use, keep the md stall in force for that cycle; the ID instruction proceeds in the following cycle.

Reset
REQ-028 SHALL, at a clk edge with reset=1, set state=RUN, md_cnt=0, md_busy=0 and md_done=0.
REQ-029 SHALL, while reset=1, drive pc_en=0, ifid_en=0, ifid_flush=idex_flush=exmem_flush=1 and pc_sel=00, regardless of other inputs.
REQ-030 SHALL abandon any in-flight mult/div when reset is asserted mid-operation, with no md_done pulse.

Structure
REQ-031 SHALL place the state encoding, the pc_sel codes and the MD_CYCLES default in shared package pipe_ctrl_pkg.
REQ-032 SHALL implement the counter as sub-module md_counter (load, decrement, zero flag).

Verification
REQ-033 SHALL cover load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; with ex_rt=0, no stall.
REQ-034 SHALL cover branch under stall: id_branch_taken=1 with load-use active -> pc_sel=00; next cycle, hazard cleared -> pc_sel=01, ifid_flush=1.
REQ-035 SHALL cover mult/div: md_start pulse with MD_CYCLES=4 -> md_busy high for 4 cycles, md_done single pulse on the 4th edge; id_md_use=1 throughout -> stalled until state returns to RUN.
REQ-036 SHALL cover exception abort: exc_req 2 cycles into MD_WAIT -> pc_sel=10, all three flushes=1, md_busy=0 next cycle, no md_done.
REQ-037 SHALL cover reset mid-operation: reset during MD_WAIT -> RUN, md_busy=0, flush outputs=1 while reset is held.
REQ-038 SHALL cover simultaneity: exc_req together with load-use and id_jump -> exception outputs only (pc_en=1, pc_sel=10).
